// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator controller: FSM states, command
// encoding, button indices and the command priority resolver.
package calc_pkg;

    localparam int DB_CYCLES_DEFAULT = 240000;
    localparam int NUM_BTNS          = 4;

    localparam int BTN_LOAD = 0;
    localparam int BTN_ADD  = 1;
    localparam int BTN_SUB  = 2;
    localparam int BTN_SHOW = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_ADD,
        CMD_SUB,
        CMD_SHOW
    } cmd_t;

    // Coincident pulses collapse to the single highest-priority command.
    function automatic cmd_t resolve_cmd(input logic [NUM_BTNS-1:0] pulses);
        cmd_t cmd;
        if (pulses[BTN_LOAD])      cmd = CMD_LOAD;
        else if (pulses[BTN_SUB])  cmd = CMD_SUB;
        else if (pulses[BTN_ADD])  cmd = CMD_ADD;
        else if (pulses[BTN_SHOW]) cmd = CMD_SHOW;
        else                       cmd = CMD_NONE;
        return cmd;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and debounced level for one raw
// button; emits a single-cycle pulse when the debounced level rises.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;
    logic             synced;

    assign synced = sync_reg[1];
    assign rise   = rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
            rise_reg <= 1'b0;
            // Any cycle back at the current level restarts the stability count.
            if (synced == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= synced;
                cnt_reg   <= '0;
                rise_reg  <= synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Button-driven 8-bit accumulator: debounced load/add/sub/show commands drive
// an IDLE/EXEC/HOLD controller that also selects what the display shows.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_load,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_show,
    input  logic [7:0] sw,
    output logic [7:0] acc,
    output logic [7:0] disp_value,
    output logic       disp_sel_acc,
    output logic       carry,
    output logic       borrow,
    output logic       op_done
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_raw[BTN_LOAD] = btn_load;
    assign btn_raw[BTN_ADD]  = btn_add;
    assign btn_raw[BTN_SUB]  = btn_sub;
    assign btn_raw[BTN_SHOW] = btn_show;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .rise   (btn_rise[gi])
            );
        end
    endgenerate

    logic [7:0] sw_meta_reg;
    logic [7:0] sw_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    cmd_t cmd;
    logic is_arith;

    assign cmd      = resolve_cmd(btn_rise);
    assign is_arith = (cmd == CMD_LOAD) || (cmd == CMD_ADD) || (cmd == CMD_SUB);

    state_t     state_reg;
    cmd_t       op_reg;
    logic [7:0] operand_reg;
    logic [7:0] acc_reg;
    logic       carry_reg;
    logic       borrow_reg;
    logic       op_done_reg;
    logic       sel_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= CMD_NONE;
            operand_reg <= '0;
            acc_reg     <= '0;
            carry_reg   <= 1'b0;
            borrow_reg  <= 1'b0;
            op_done_reg <= 1'b0;
            sel_reg     <= 1'b0;
        end else begin
            op_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (is_arith) begin
                        op_reg    <= cmd;
                        state_reg <= EXEC;
                    end else if (cmd == CMD_SHOW) begin
                        sel_reg <= ~sel_reg;
                    end
                end
                EXEC: begin
                    // Commands arriving now are dropped; the operand is sampled here.
                    operand_reg <= sw_sync_reg;
                    op_done_reg <= 1'b1;
                    sel_reg     <= 1'b1;
                    state_reg   <= HOLD;
                    case (op_reg)
                        CMD_LOAD: begin
                            acc_reg    <= sw_sync_reg;
                            carry_reg  <= 1'b0;
                            borrow_reg <= 1'b0;
                        end
                        CMD_ADD: begin
                            {carry_reg, acc_reg} <= {1'b0, acc_reg} + {1'b0, sw_sync_reg};
                            borrow_reg <= 1'b0;
                        end
                        CMD_SUB: begin
                            acc_reg    <= acc_reg - sw_sync_reg;
                            borrow_reg <= (sw_sync_reg > acc_reg);
                            carry_reg  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (is_arith) begin
                        op_reg    <= cmd;
                        state_reg <= EXEC;
                    end else if (sw_sync_reg != operand_reg) begin
                        sel_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cmd == CMD_SHOW) begin
                        sel_reg <= ~sel_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign acc          = acc_reg;
    assign carry        = carry_reg;
    assign borrow       = borrow_reg;
    assign op_done      = op_done_reg;
    assign disp_sel_acc = sel_reg;
    assign disp_value   = sel_reg ? acc_reg : sw_sync_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed and randomized checks of calc_ctrl against an arithmetic reference
// model of the accumulator and display selection.
module tb_calc_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_load = 1'b0;
    logic       btn_add = 1'b0;
    logic       btn_sub = 1'b0;
    logic       btn_show = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] acc;
    logic [7:0] disp_value;
    logic       disp_sel_acc;
    logic       carry;
    logic       borrow;
    logic       op_done;

    calc_ctrl #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_load    (btn_load),
        .btn_add     (btn_add),
        .btn_sub     (btn_sub),
        .btn_show    (btn_show),
        .sw          (sw),
        .acc         (acc),
        .disp_value  (disp_value),
        .disp_sel_acc(disp_sel_acc),
        .carry       (carry),
        .borrow      (borrow),
        .op_done     (op_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always @(negedge clk) if (op_done === 1'b1) done_cnt++;

    // Reference model state
    logic [7:0] m_acc = 8'h00;
    logic       m_carry = 1'b0;
    logic       m_borrow = 1'b0;
    logic       m_sel = 1'b0;
    logic       m_hold = 1'b0;
    logic [7:0] m_operand = 8'h00;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".acc"}, {1'b0, acc}, {1'b0, m_acc});
        check({tag, ".carry"}, {8'h00, carry}, {8'h00, m_carry});
        check({tag, ".borrow"}, {8'h00, borrow}, {8'h00, m_borrow});
        check({tag, ".sel"}, {8'h00, disp_sel_acc}, {8'h00, m_sel});
        check({tag, ".disp"}, {1'b0, disp_value}, {1'b0, (m_sel ? m_acc : sw)});
    endtask

    // op: 0 load, 1 add, 2 sub
    task automatic model_op(input int op, input logic [7:0] v);
        int s;
        case (op)
            0: begin
                m_acc = v; m_carry = 1'b0; m_borrow = 1'b0;
            end
            1: begin
                s = int'(m_acc) + int'(v);
                m_carry = (s > 255);
                m_acc = 8'(s % 256);
                m_borrow = 1'b0;
            end
            default: begin
                s = int'(m_acc) - int'(v);
                m_borrow = (v > m_acc);
                if (s < 0) s += 256;
                m_acc = 8'(s);
                m_carry = 1'b0;
            end
        endcase
        m_hold = 1'b1;
        m_sel = 1'b1;
        m_operand = v;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            0: btn_load = val;
            1: btn_add  = val;
            2: btn_sub  = val;
            default: btn_show = val;
        endcase
    endtask

    task automatic set_sw(input logic [7:0] v);
        sw = v;
        if (m_hold && (v != m_operand)) begin
            m_hold = 1'b0;
            m_sel = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("sw_change", {1'b0, disp_value}, {1'b0, (m_sel ? m_acc : v)});
    endtask

    task automatic do_op(input int op, input logic [7:0] v);
        int d0;
        set_sw(v);
        d0 = done_cnt;
        set_btn(op, 1'b1);
        repeat (DB + 4) @(posedge clk);
        #1;
        model_op(op, v);
        check("op_done_pulse", {8'h00, op_done}, 9'h001);
        check_outputs("op");
        $display("op=%0d sw=%02h acc=%02h carry=%0b borrow=%0b sel=%0b", op, v, acc, carry, borrow, disp_sel_acc);
        @(posedge clk);
        #1;
        check("op_done_single", {8'h00, op_done}, 9'h000);
        set_btn(op, 1'b0);
        repeat (DB + 4) @(posedge clk);
        #1;
        check("release_no_cmd", 9'(done_cnt - d0), 9'd1);
        check_outputs("release");
    endtask

    task automatic show_press();
        set_btn(3, 1'b1);
        repeat (DB + 3) @(posedge clk);
        #1;
        m_sel = ~m_sel;
        check("show_toggle", {8'h00, disp_sel_acc}, {8'h00, m_sel});
        check("show_disp", {1'b0, disp_value}, {1'b0, (m_sel ? m_acc : sw)});
        $display("show sel=%0b disp=%02h", disp_sel_acc, disp_value);
        set_btn(3, 1'b0);
        repeat (DB + 4) @(posedge clk);
        #1;
        check("show_release", {8'h00, disp_sel_acc}, {8'h00, m_sel});
    endtask

    initial begin
        int d0;
        int op;
        logic [7:0] v;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.op_done", {8'h00, op_done}, 9'h000);
        check_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Load 0x12
        do_op(0, 8'h12);

        // 0xF0 + 0x20 wraps with carry, then operand change returns to IDLE
        do_op(0, 8'hF0);
        do_op(1, 8'h20);
        set_sw(8'h21);
        check("idle_sel", {8'h00, disp_sel_acc}, 9'h000);
        check("idle_disp", {1'b0, disp_value}, 9'h021);

        // Subtraction with and without borrow
        do_op(0, 8'h05);
        do_op(2, 8'h07);
        do_op(0, 8'h07);
        do_op(2, 8'h07);

        // Bouncing add button: only the final stable press executes
        set_sw(8'h03);
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_add = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        btn_add = 1'b1;
        repeat (DB + 10) @(posedge clk);
        #1;
        model_op(1, 8'h03);
        check("bounce_count", 9'(done_cnt - d0), 9'd1);
        check_outputs("bounce");
        btn_add = 1'b0;
        repeat (DB + 4) @(posedge clk);
        #1;
        check("bounce_release", 9'(done_cnt - d0), 9'd1);

        // Load and sub together: load wins, sub dropped
        set_sw(8'h44);
        d0 = done_cnt;
        btn_load = 1'b1;
        btn_sub = 1'b1;
        repeat (DB + 10) @(posedge clk);
        #1;
        model_op(0, 8'h44);
        check("prio_count", 9'(done_cnt - d0), 9'd1);
        check_outputs("prio");
        btn_load = 1'b0;
        btn_sub = 1'b0;
        repeat (DB + 4) @(posedge clk);
        #1;
        check("prio_release", 9'(done_cnt - d0), 9'd1);

        // Show twice in IDLE
        set_sw(8'h45);
        check("show_idle_start", {8'h00, disp_sel_acc}, 9'h000);
        show_press();
        show_press();

        // Randomized operations with occasional show presses
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(0, 2));
            v = 8'($urandom_range(0, 255));
            do_op(op, v);
            if ($urandom_range(0, 3) == 0) show_press();
        end

        // Reset during EXEC aborts the add; held button gives one add afterwards
        do_op(0, 8'h44);
        set_sw(8'h30);
        btn_add = 1'b1;
        repeat (DB + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_acc = 8'h00; m_carry = 1'b0; m_borrow = 1'b0; m_sel = 1'b0; m_hold = 1'b0;
        check("rst_exec.op_done", {8'h00, op_done}, 9'h000);
        check("rst_exec.acc", {1'b0, acc}, 9'h000);
        check("rst_exec.carry", {8'h00, carry}, 9'h000);
        check("rst_exec.borrow", {8'h00, borrow}, 9'h000);
        check("rst_exec.sel", {8'h00, disp_sel_acc}, 9'h000);
        check("rst_exec.disp", {1'b0, disp_value}, 9'h000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (DB + 4) @(posedge clk);
        #1;
        model_op(1, 8'h30);
        check("held_add.op_done", {8'h00, op_done}, 9'h001);
        check_outputs("held_add");
        repeat (10) @(posedge clk);
        #1;
        check("held_add.count", 9'(done_cnt - d0), 9'd1);
        btn_add = 1'b0;
        repeat (DB + 4) @(posedge clk);
        #1;
        check("held_add.release", 9'(done_cnt - d0), 9'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 240000, consecutive stable cycles required to accept a button level change (20 ms at 12 MHz).
REQ-002 CLK  input  1  single clock; all state on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 btn_load  input  1  raw, active-high: load sw into accumulator.
REQ-005 btn_add  input  1  raw, active-high: acc = acc + sw.
REQ-006 btn_sub  input  1  raw, active-high: acc = acc - sw.
REQ-007 btn_show  input  1  raw, active-high: toggle display source.
REQ-008 sw  input  8  raw operand switches, asynchronous.
REQ-009 acc  output  8  accumulator value.
REQ-010 disp_value  output  8  value for the seven-segment path.
REQ-011 disp_sel_acc  output  1  1 = disp_value shows acc, 0 = synced sw.
REQ-012 carry  output  1  carry out of last add.
REQ-013 borrow  output  1  borrow of last subtract.
REQ-014 op_done  output  1  one-cycle pulse after each accumulator update.

Function
REQ-015 All buttons and sw SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Each synced button SHALL change its debounced level only after DB_CYCLES consecutive cycles at the new level; any bounce restarts the count.
REQ-017 A debounced 0->1 transition SHALL produce exactly one single-cycle command pulse; release produces none.
REQ-018 Simultaneous pulses in one cycle SHALL resolve by priority load > sub > add > show; losers are dropped, not queued.
REQ-019 FSM states: IDLE, EXEC, HOLD.
REQ-020 IDLE: disp_sel_acc=0; load/add/sub pulse -> EXEC; show pulse toggles disp_sel_acc, stays IDLE.
REQ-021 EXEC lasts exactly one cycle; operand is synced sw in that cycle; acc, carry, borrow update on the edge ending EXEC; next state HOLD.
REQ-022 op_done SHALL be 1 in the first HOLD cycle only.
REQ-023 Latency: command pulse in cycle t -> EXEC in t+1 -> acc/op_done visible in t+2.
REQ-024 Command pulses arriving during EXEC SHALL be ignored.
REQ-025 HOLD: disp_sel_acc=1; new load/add/sub -> EXEC; show toggles disp_sel_acc; synced sw differing from the EXEC-captured operand -> IDLE.
REQ-026 Add: {carry, acc} = acc + sw (9-bit), borrow cleared; wraps mod 256.
REQ-027 Sub: acc = (acc - sw) mod 256, borrow = (sw > acc), carry cleared.
REQ-028 Load: acc = sw, carry and borrow cleared.
REQ-029 disp_value SHALL equal acc when disp_sel_acc=1, else synced sw, combinationally.

Reset
REQ-030 RST_N low SHALL immediately force acc=0, carry=0, borrow=0, op_done=0, disp_sel_acc=0, state IDLE, debounced levels 0, counters 0, synchronizers 0.
REQ-031 Reset asserted mid-EXEC SHALL abort the operation; acc reads 0 after release.
REQ-032 A button held through reset release SHALL produce exactly one command after DB_CYCLES+2 cycles.

Structure
REQ-033 Shared package calc_pkg SHALL hold the FSM state enum, command encoding (NONE/LOAD/ADD/SUB/SHOW) and default DB_CYCLES.
REQ-034 Sub-module btn_debounce (sync, counter, debounced level, rise pulse) SHALL be instantiated once per button.
REQ-035 Implementation SHALL use no clock other than CLK and no gated or derived clocks.

Verification (DB_CYCLES=4)
REQ-036 sw=0x12, press load -> acc=0x12, carry=0, borrow=0, op_done one pulse, disp_value=0x12.
REQ-037 acc=0xF0, sw=0x20, press add -> acc=0x10, carry=1; sw changes to 0x21 -> IDLE, disp_value=0x21.
REQ-038 acc=0x05, sw=0x07, press sub -> acc=0xFE, borrow=1; acc=0x07, sw=0x07 sub -> acc=0x00, borrow=0.
REQ-039 add toggling every 2 cycles for 20 cycles then held -> exactly one add executes.
REQ-040 load and sub rising in same cycle -> only load executes; show in IDLE twice -> disp_sel_acc 0->1->0.
REQ-041 RST_N low during EXEC -> all outputs 0 immediately; held btn_add through release -> one add at DB_CYCLES+2 cycles.
